// File: rtl/maze_carver_dfs.sv
// ---------------------------------------------------------------------------
// maze_carver_dfs
//   Depth-first (recursive-backtracker) perfect-maze generator. It carves a
//   maze over a runtime-selected grid of up to MAX_X x MAX_Y cells. The result
//   is a wall/path bitmap in which walls are explicit cells. Each CARVE step
//   takes exactly one clock, so a grid of N cells finishes 2N edges after the
//   edge that accepts start.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   start        begin generation (accepted only in IDLE or DONE)
//   seed         LFSR seed, loaded on accepted start (0 selects 16'hACE1)
//   x_dimension  active cells in x, latched and clamped on start
//   y_dimension  active cells in y, latched and clamped on start
//   maze_data    bitmap, bit gx+gy*GW, 1=path 0=wall
//   busy         high while clearing or carving
//   done         level, high from completion until the next start or reset
//   curr_x/y     cursor cell coordinates
//
// MAX_X and MAX_Y are expected to be at least 2.
// ---------------------------------------------------------------------------
module maze_carver_dfs #(
  parameter int MAX_X = 16,
  parameter int MAX_Y = 16,
  parameter int GW    = 2*MAX_X+1,
  parameter int GH    = 2*MAX_Y+1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [15:0]                seed,
  input  logic [$clog2(MAX_X+1)-1:0] x_dimension,
  input  logic [$clog2(MAX_Y+1)-1:0] y_dimension,
  output logic [GW*GH-1:0]           maze_data,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(MAX_X)-1:0]   curr_x,
  output logic [$clog2(MAX_Y)-1:0]   curr_y
);

  localparam int XDW   = $clog2(MAX_X+1);
  localparam int YDW   = $clog2(MAX_Y+1);
  localparam int CXW   = $clog2(MAX_X);
  localparam int CYW   = $clog2(MAX_Y);
  localparam int NBITS = GW*GH;
  localparam int IW    = $clog2(NBITS);
  localparam int DEPTH = MAX_X*MAX_Y;
  localparam int SAW   = $clog2(DEPTH);
  localparam int SPW   = $clog2(DEPTH+1);

  localparam logic [15:0]       LFSR_INIT = 16'hACE1;
  // Only cell (0,0), i.e. bitmap (1,1), open.
  localparam logic [NBITS-1:0]  ORIGIN    = NBITS'(1) << (GW+1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_CARVE, S_DONE} state_t;

  state_t                 r_state;
  logic [XDW-1:0]         r_x_dim;
  logic [YDW-1:0]         r_y_dim;
  logic [SPW-1:0]         r_sp;
  logic [15:0]            r_lfsr;
  logic [CXW+CYW-1:0]     r_stack [DEPTH];

  logic [3:0]             w_mask;
  logic                   w_found;
  logic [1:0]             w_dir;
  logic [CXW-1:0]         w_nx;
  logic [CYW-1:0]         w_ny;
  logic [IW-1:0]          w_wall_idx;
  logic [IW-1:0]          w_cell_idx;
  logic [SPW-1:0]         w_sp_m1;
  logic [CXW+CYW-1:0]     w_top;

  function automatic logic [IW-1:0] bit_idx(input int gx, input int gy);
    return IW'(gx + gy*GW);
  endfunction

  // Direction offsets: 0=up(-y) 1=left(-x) 2=down(+y) 3=right(+x).
  function automatic int dir_dx(input int d);
    case (d)
      1:       return -1;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int dir_dy(input int d);
    case (d)
      0:       return -1;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [XDW-1:0] clamp_x(input logic [XDW-1:0] v);
    if (v == '0)              return XDW'(1);
    else if (int'(v) > MAX_X) return XDW'(MAX_X);
    else                      return v;
  endfunction

  function automatic logic [YDW-1:0] clamp_y(input logic [YDW-1:0] v);
    if (v == '0)              return YDW'(1);
    else if (int'(v) > MAX_Y) return YDW'(MAX_Y);
    else                      return v;
  endfunction

  // Neighbour selection: in-grid unvisited neighbours, then the first set
  // direction scanning upward (mod 4) from the LFSR's low two bits.
  always_comb begin
    int         cx, cy, nx, ny;
    logic [1:0] d2;
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_mask     = '0;
    w_found    = 1'b0;
    w_dir      = '0;
    d2         = '0;
    cx         = int'(curr_x);
    cy         = int'(curr_y);
    for (int d = 0; d < 4; d++) begin
      nx = cx + dir_dx(d);
      ny = cy + dir_dy(d);
      if (nx >= 0 && nx < int'(r_x_dim) && ny >= 0 && ny < int'(r_y_dim))
        w_mask[d[1:0]] = ~maze_data[bit_idx(2*nx+1, 2*ny+1)];
    end
    for (int k = 0; k < 4; k++) begin
      d2 = r_lfsr[1:0] + k[1:0];
      if (!w_found && w_mask[d2]) begin
        w_found = 1'b1;
        w_dir   = d2;
      end
    end
    nx         = cx + dir_dx(int'(w_dir));
    ny         = cy + dir_dy(int'(w_dir));
    w_nx       = CXW'(nx);
    w_ny       = CYW'(ny);
    w_cell_idx = bit_idx(2*nx+1, 2*ny+1);
    w_wall_idx = bit_idx(2*cx+1+dir_dx(int'(w_dir)), 2*cy+1+dir_dy(int'(w_dir)));
  end

  assign w_sp_m1 = r_sp - 1'b1;
  assign w_top   = r_stack[w_sp_m1[SAW-1:0]];

  // NOTE: the stack is plain storage with no reset; the pointer alone defines
  // which entries are valid, which lets this map onto a RAM.
  always_ff @(posedge clk) begin
    if (r_state == S_CARVE && w_found)
      r_stack[r_sp[SAW-1:0]] <= {curr_x, curr_y};
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_x_dim   <= XDW'(1);
      r_y_dim   <= YDW'(1);
      r_sp      <= '0;
      r_lfsr    <= LFSR_INIT;
      maze_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      curr_x    <= '0;
      curr_y    <= '0;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_lfsr  <= (seed == 16'h0000) ? LFSR_INIT : seed;
            r_x_dim <= clamp_x(x_dimension);
            r_y_dim <= clamp_y(y_dimension);
            busy    <= 1'b1;
            done    <= 1'b0;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          maze_data <= ORIGIN;
          curr_x    <= '0;
          curr_y    <= '0;
          r_sp      <= '0;
          r_state   <= S_CARVE;
        end
        S_CARVE: begin
          if (w_found) begin
            maze_data[w_wall_idx] <= 1'b1;
            maze_data[w_cell_idx] <= 1'b1;
            curr_x                <= w_nx;
            curr_y                <= w_ny;
            r_sp                  <= r_sp + 1'b1;
          end else if (r_sp != '0) begin
            {curr_x, curr_y} <= w_top;
            r_sp             <= w_sp_m1;
          end else begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
